// File: rtl/cic_cfg_sequencer.sv
// cic_cfg_sequencer: loads per-stage CIC config words over a shared bus using the isConfig/ACK/Done handshake
// Optional build macro CIC_CFG_AUTO_RETRY_EN: one 4-cycle-backoff retry per target before reporting a timeout.
module cic_cfg_sequencer #(
   parameter int NUM_TARGETS    = 3,
   parameter int CFG_DATA_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic                      Host_Wr,
   input  logic [2:0]                Host_Addr,
   input  logic [CFG_DATA_WIDTH-1:0] Host_WData,
   input  logic                      Host_Start,
   output logic                      Host_Busy,
   output logic                      Host_Done,
   output logic                      Host_Err,
   output logic [2:0]                Host_ErrIdx,
   output logic [NUM_TARGETS-1:0]    Cfg_Req,
   output logic [CFG_DATA_WIDTH-1:0] Cfg_Data,
   input  logic [NUM_TARGETS-1:0]    Cfg_Ack,
   input  logic [NUM_TARGETS-1:0]    Cfg_Done
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT_DONE, NEXT, FINISH, ERR, RETRY} stateType;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 4);
   localparam logic [2:0] LAST = 3'(NUM_TARGETS - 1);
   logic [CFG_DATA_WIDTH-1:0] cfgMem [8];
   stateType state, stateNext, failState;
   logic [2:0] idx, idxNext;
   logic [CW-1:0] waitCnt;
   logic [NUM_TARGETS-1:0] sel;
   logic ackHit, doneHit, timeout;
   assign sel       = NUM_TARGETS'(1) << idx;
   assign ackHit    = |(Cfg_Ack & sel);
   assign doneHit   = |(Cfg_Done & sel);
   assign timeout   = waitCnt == CW'(TIMEOUT_CYCLES - 1);
   assign Cfg_Req   = (state == REQ) ? sel : '0;
   assign Host_Busy = state inside {REQ, WAIT_DONE, NEXT, RETRY};
   assign Host_Done = state == FINISH;
`ifdef CIC_CFG_AUTO_RETRY_EN
   logic retried;
   assign failState = retried ? ERR : RETRY;
   // retry budget: one backoff per target, rearmed whenever a new target starts
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) retried <= 1'b0;
      else if (state == IDLE || state == NEXT) retried <= 1'b0;
      else if (stateNext == RETRY) retried <= 1'b1;
`else
   assign failState = ERR;
`endif
   // register file, frozen while a sequence runs; out-of-range targets dropped
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) for (int i = 0; i < 8; i++) cfgMem[i] <= '0;
      else if (Host_Wr && !Host_Busy && {1'b0, Host_Addr} < 4'(NUM_TARGETS)) cfgMem[Host_Addr] <= Host_WData;
   // next-state: only the addressed target's ACK/Done can move the FSM
   always_comb begin
      stateNext = state;
      idxNext   = idx;
      case (state)
         IDLE:      if (Host_Start) begin
                       stateNext = REQ;
                       idxNext   = '0;
                    end
         REQ:       stateNext = ackHit ? WAIT_DONE : timeout ? failState : REQ;
         WAIT_DONE: stateNext = doneHit ? NEXT : timeout ? failState : WAIT_DONE;
         NEXT:      if (idx == LAST) stateNext = FINISH;
                    else begin
                       stateNext = REQ;
                       idxNext   = idx + 3'd1;
                    end
         RETRY:     stateNext = (waitCnt == CW'(3)) ? REQ : RETRY;
         default:   stateNext = IDLE;
      endcase
   end
   // state, wait counter, data bus and sticky error reporting
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         state       <= IDLE;
         idx         <= '0;
         waitCnt     <= '0;
         Cfg_Data    <= '0;
         Host_Err    <= 1'b0;
         Host_ErrIdx <= '0;
      end else begin
         state   <= stateNext;
         idx     <= idxNext;
         waitCnt <= (stateNext != state) ? '0 : waitCnt + 1'b1;
         if (stateNext == REQ && state != REQ) Cfg_Data <= cfgMem[idxNext];
         if (state == IDLE && Host_Start) Host_Err <= 1'b0;
         else if (stateNext == ERR && state != ERR) begin
            Host_Err    <= 1'b1;
            Host_ErrIdx <= idx;
         end
      end
endmodule

// File: tb/tb_cic_cfg_sequencer.sv
// tb_cic_cfg_sequencer: directed checks of the CIC config sequencer against zero-wait stage models
module tb_cic_cfg_sequencer;
   logic        CLK = 0, nRST = 0;
   logic        Host_Wr = 0, Host_Start = 0;
   logic [2:0]  Host_Addr = 0;
   logic [15:0] Host_WData = 0;
   logic        Host_Busy, Host_Done, Host_Err;
   logic [2:0]  Host_ErrIdx, Cfg_Req, Cfg_Ack, Cfg_Done;
   logic [15:0] Cfg_Data;
   logic [2:0]  ackEn = 3'b111, spurAck = 0, spurDone = 0, mAck, p1, p2, mDone;
   logic [15:0] lat [3];
   int latCnt [3] = '{0, 0, 0};
   int baseLat [3];
   int doneCnt = 0, req2Cnt = 0, multiHot = 0, baseDone, baseReq2;
   logic [11:0] reqSeq = 0;
   logic [2:0]  prevReq = 0;
   int nChk = 0, nFail = 0, cyc, n;

   cic_cfg_sequencer dut (
      .CLK(CLK), .nRST(nRST), .Host_Wr(Host_Wr), .Host_Addr(Host_Addr), .Host_WData(Host_WData),
      .Host_Start(Host_Start), .Host_Busy(Host_Busy), .Host_Done(Host_Done), .Host_Err(Host_Err),
      .Host_ErrIdx(Host_ErrIdx), .Cfg_Req(Cfg_Req), .Cfg_Data(Cfg_Data), .Cfg_Ack(Cfg_Ack), .Cfg_Done(Cfg_Done)
   );

   always #5 CLK = ~CLK;

   assign Cfg_Ack  = mAck | spurAck;
   assign Cfg_Done = mDone | spurDone;

   // zero-wait stages: ACK one cycle after Req, Done two cycles after ACK
   always @(posedge CLK or negedge nRST)
      if (!nRST) {mAck, p1, p2, mDone} <= '0;
      else begin
         mAck  <= Cfg_Req & ackEn;
         p1    <= Cfg_Req & ackEn & ~mAck;
         p2    <= p1;
         mDone <= p2;
      end

   // stage latches data the cycle after its ACK; bus observers
   always @(posedge CLK) begin
      for (int i = 0; i < 3; i++)
         if (p1[i]) begin
            lat[i]    <= Cfg_Data;
            latCnt[i] <= latCnt[i] + 1;
         end
      prevReq <= Cfg_Req;
      if (Cfg_Req != 0 && Cfg_Req != prevReq) reqSeq <= {reqSeq[8:0], Cfg_Req};
      if ($countones(Cfg_Req) > 1) multiHot <= multiHot + 1;
      if (Cfg_Req[2]) req2Cnt <= req2Cnt + 1;
      if (Host_Done) doneCnt <= doneCnt + 1;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChk++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      Host_Wr = 1; Host_Addr = a; Host_WData = d;
      tick;
      Host_Wr = 0;
   endtask

   task automatic snap;
      for (int i = 0; i < 3; i++) baseLat[i] = latCnt[i];
      baseDone = doneCnt;
      baseReq2 = req2Cnt;
   endtask

   // counts cycles with the Start cycle as cycle 1, bounded
   task automatic waitDone(output int c);
      c = 1;
      while (!Host_Done && c < 400) begin
         tick;
         Host_Start = 0;
         c++;
      end
   endtask

   task automatic chkLat(input string tag, input logic [15:0] d0, d1, d2);
      tick; tick; tick;
      chk({tag, "_lat0"}, 32'(lat[0]), 32'(d0));
      chk({tag, "_lat1"}, 32'(lat[1]), 32'(d1));
      chk({tag, "_lat2"}, 32'(lat[2]), 32'(d2));
      for (int i = 0; i < 3; i++) chk({tag, "_latcnt"}, 32'(latCnt[i] - baseLat[i]), 1);
      chk({tag, "_donecnt"}, 32'(doneCnt - baseDone), 1);
   endtask

   initial begin
      repeat (3) tick;
      chk("rst_outs", {Host_Busy, Host_Done, Host_Err, Host_ErrIdx, Cfg_Req}, 0);
      chk("rst_data", 32'(Cfg_Data), 0);
      nRST = 1;
      tick;
      wr(0, 16'h0005); wr(1, 16'h0003); wr(2, 16'h000D);

      // 1: nominal sequence
      snap;
      Host_Start = 1;
      waitDone(cyc);
      chk("t1_latency", 32'(cyc), 17);
      tick;
      chk("t1_done_width", 32'(Host_Done), 0);
      chk("t1_order", 32'(reqSeq[8:0]), 32'(9'b001_010_100));
      chk("t1_err", 32'(Host_Err), 0);
      chkLat("t1", 16'h0005, 16'h0003, 16'h000D);

      // 3: write and start while busy are ignored
      snap;
      Host_Start = 1; tick; Host_Start = 0; tick;
      wr(0, 16'hFFFF);
      tick;
      Host_Start = 1; tick; Host_Start = 0;
      waitDone(cyc);
      repeat (30) tick;
      chk("t3_busy", 32'(Host_Busy), 0);
      chkLat("t3", 16'h0005, 16'h0003, 16'h000D);

      // 4: spurious ACK/Done from target 2 while target 0 is pending
      snap;
      ackEn = 3'b110; spurAck = 3'b100; spurDone = 3'b100;
      Host_Start = 1; tick; Host_Start = 0;
      repeat (6) tick;
      chk("t4_req", 32'(Cfg_Req), 1);
      chk("t4_data", 32'(Cfg_Data), 16'h0005);
      chk("t4_busy", 32'(Host_Busy), 1);
      spurAck = 0; spurDone = 0; ackEn = 3'b111;
      waitDone(cyc);
      chkLat("t4", 16'h0005, 16'h0003, 16'h000D);

      // 2: target 1 never acknowledges
      snap;
      ackEn = 3'b101;
      Host_Start = 1; tick; Host_Start = 0;
      n = 0;
      while (!Cfg_Req[1] && n < 50) begin tick; n++; end
      n = 0;
      while (Cfg_Req[1] && n < 200) begin tick; n++; end
      chk("t2_req_hi", 32'(n), 64);
`ifdef CIC_CFG_AUTO_RETRY_EN
      n = 0;
      while (!Cfg_Req[1] && n < 50) begin tick; n++; end
      chk("t2_backoff", 32'(n), 4);
      n = 0;
      while (Cfg_Req[1] && n < 200) begin tick; n++; end
      chk("t2_req_hi2", 32'(n), 64);
`endif
      chk("t2_err", 32'(Host_Err), 1);
      chk("t2_erridx", 32'(Host_ErrIdx), 1);
      chk("t2_busy", 32'(Host_Busy), 0);
      repeat (10) tick;
      chk("t2_err_sticky", 32'(Host_Err), 1);
      chk("t2_nodone", 32'(doneCnt - baseDone), 0);
      chk("t2_noreq2", 32'(req2Cnt - baseReq2), 0);
      ackEn = 3'b111;
      Host_Start = 1; tick; Host_Start = 0;
      chk("t2_err_clear", 32'(Host_Err), 0);
      waitDone(cyc);
      chk("t2_rerun_done", 32'(Host_Done), 1);

      // 5: reset in WAIT_DONE of target 1
      repeat (3) tick;
      Host_Start = 1; tick; Host_Start = 0;
      n = 0;
      while (Cfg_Req != 3'b010 && n < 50) begin tick; n++; end
      n = 0;
      while (Cfg_Req != 0 && n < 50) begin tick; n++; end
      chk("t5_in_wait", 32'(Host_Busy), 1);
      #2 nRST = 0;
      #1;
      chk("t5_outs", {Host_Busy, Host_Done, Host_Err, Host_ErrIdx, Cfg_Req}, 0);
      chk("t5_data", 32'(Cfg_Data), 0);
      tick; tick;
      nRST = 1;
      tick; tick;
      snap;
      Host_Start = 1; tick; Host_Start = 0;
      chk("t5_restart", 32'(Cfg_Req), 1);
      waitDone(cyc);
      chkLat("t5", 16'h0, 16'h0, 16'h0);

      // 6: write to a non-existent target
      wr(0, 16'h0005); wr(1, 16'h0003); wr(2, 16'h000D);
      wr(5, 16'hBEEF);
      snap;
      Host_Start = 1;
      waitDone(cyc);
      chkLat("t6", 16'h0005, 16'h0003, 16'h000D);
      chk("onehot", 32'(multiHot), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end
endmodule

// File: doc/cic_cfg_sequencer.md
Name: cic_cfg_sequencer

Overview:
Configuration controller for the multichannel CIC decimator chain (integrator, comb, output scaler). Host software writes one 16-bit configuration word per CIC stage into a small register file, then issues a start. The sequencer configures each stage in turn over a shared config bus using the per-stage isConfig/ACK/Done handshake, and reports completion or timeout to the host.

Parameters:
NUM_TARGETS, 3, number of CIC stages sequenced (1..8); index 0 is configured first.
CFG_DATA_WIDTH, 16, config word width; matches the stage config bus.
TIMEOUT_CYCLES, 64, maximum CLK cycles to wait for each ACK and for each Done.

Ports:
CLK  in  1  system clock
nRST  in  1  reset, asynchronous, active-low
Host_Wr  in  1  write strobe for the register file
Host_Addr  in  3  target index written by Host_Wr
Host_WData  in  CFG_DATA_WIDTH  config word
Host_Start  in  1  single-cycle start pulse
Host_Busy  out  1  high while a sequence runs
Host_Done  out  1  one-cycle pulse when all targets are configured
Host_Err  out  1  sticky timeout flag; cleared by the next accepted Host_Start
Host_ErrIdx  out  3  target index that timed out
Cfg_Req  out  NUM_TARGETS  per-target isConfig, one-hot or zero
Cfg_Data  out  CFG_DATA_WIDTH  shared config data bus
Cfg_Ack  in  NUM_TARGETS  per-target isCOnfigACK (level)
Cfg_Done  in  NUM_TARGETS  per-target isConfigDone (pulse)

Behaviour:
- Reset values: all outputs 0, register file all 0, FSM in IDLE.
- Register file: Host_Wr writes cfg_mem[Host_Addr] on the CLK edge. Writes with Host_Addr >= NUM_TARGETS are ignored. Writes while Host_Busy=1 are ignored, so the file is frozen during a sequence.
- FSM states: IDLE, REQ, WAIT_DONE, NEXT, FINISH, ERR.
- IDLE: when Host_Start=1, set idx=0, clear Host_Err, set Host_Busy=1, go to REQ. Host_Start is ignored in all other states.
- REQ: drive Cfg_Req[idx]=1 and Cfg_Data=cfg_mem[idx]. On the first cycle Cfg_Ack[idx]=1, drop Cfg_Req the next cycle and go to WAIT_DONE. Cfg_Req must not stay high after ACK, because a stage in its normal-work state would re-enter config.
- WAIT_DONE: hold Cfg_Data stable; the stage latches the data one cycle after its ACK. When Cfg_Done[idx]=1, go to NEXT.
- Cfg_Data is valid from entry to REQ until the cycle after Done. In all other states Cfg_Data holds its last value.
- NEXT: if idx == NUM_TARGETS-1, go to FINISH; otherwise idx++ and go to REQ. This gives one idle cycle between targets.
- FINISH: Host_Done=1 for exactly one cycle, Host_Busy=0, return to IDLE.
- Timeout: a wait counter resets on entry to REQ and on entry to WAIT_DONE. If it reaches TIMEOUT_CYCLES without the awaited input, go to ERR.
- ERR: Host_Err=1, Host_ErrIdx=idx, Cfg_Req=0, Host_Busy=0, no Host_Done, return to IDLE. Remaining targets are not configured.
- Ack/Done from targets other than idx are ignored.
- If Done arrives in the same cycle as ACK, still pass through WAIT_DONE. Done is recognised only while in WAIT_DONE.
- Latency with zero-wait stages (ACK one cycle after Req, Done two cycles after ACK): 5 cycles per target, plus 1 cycle each for start and finish.
- Reset mid-sequence: everything returns to reset values immediately. Cfg_Req drops asynchronously.

Optional Feature:
CIC_CFG_AUTO_RETRY_EN:
- Defined: on the first timeout of a target, deassert Cfg_Req for 4 cycles, then re-enter REQ for the same idx. A second timeout on that idx goes to ERR. The retry budget resets per target.
- Not defined: the first timeout goes straight to ERR.

Test Plan:
1. Write cfg_mem = {0x0005, 0x0003, 0x000D}, pulse Host_Start, zero-wait model stages. Required: Cfg_Req one-hot 001 -> 010 -> 100 in order; each stage latches exactly 0x0005/0x0003/0x000D; a single Host_Done pulse 17 cycles after Host_Start; Host_Err=0.
2. Target 1 never asserts ACK. Required: Cfg_Req[1] drops after 64 cycles; Host_Err=1, Host_ErrIdx=1; no Host_Done; Cfg_Req[2] never asserted. With CIC_CFG_AUTO_RETRY_EN, Cfg_Req[1] re-asserts 4 cycles after the drop, then ERR after the second 64-cycle wait.
3. Host_Wr to address 0 with 0xFFFF during Busy, and Host_Start during Busy. Required: both ignored; stage 0 keeps its original word; only one sequence runs.
4. Spurious Cfg_Ack[2] and Cfg_Done[2] while configuring target 0. Required: no state change and no early advance.
5. nRST asserted while in WAIT_DONE for target 1. Required: all outputs 0 immediately; the next Host_Start restarts at target 0.
6. Write to Host_Addr=5 with NUM_TARGETS=3. Required: register file unchanged, as confirmed by a subsequent sequence.
